// File: rtl/fft_addr_gen.sv
// fft_addr_gen -- per-level butterfly address sequencer for an in-place
// radix-2 DIT FFT whose input is already in bit-reversed order.
//
// A go pulse in IDLE latches the stage index s. From the next cycle on, the
// block issues N/2 butterfly read requests, one per cycle. Each request has
// two operand addresses (A, B) and a twiddle ROM index. Every request is also
// pushed through a BFLY_LATENCY-deep delay line, which produces the matching
// write strobe and write addresses once the butterfly result is ready.
//
// Ports
//   clk            : clock
//   reset          : synchronous, active-high reset
//   addr_gen_go    : start one level (sampled only while idle)
//   fft_level      : stage index s, sampled together with go
//   addr_gen_busy  : high while read requests are being issued
//   level_err      : one-cycle pulse, go received with an out-of-range level
//   rd_en          : read request valid
//   rd_addr_a/b    : operand A/B read addresses
//   tw_addr        : twiddle ROM index, aligned with rd_en
//   wr_en          : rd_en delayed BFLY_LATENCY cycles
//   wr_addr_a/b    : rd_addr_a/b delayed BFLY_LATENCY cycles
//   fft_data_valid : copy of wr_en for the controller's flush wait
module fft_addr_gen #(
    parameter int FFT_SIZE     = 4096,
    parameter int BFLY_LATENCY = 6,
    localparam int LEVELS = $clog2(FFT_SIZE),
    localparam int ADDR_W = LEVELS,
    localparam int LVL_W  = $clog2(LEVELS),
    localparam int TW_W   = LEVELS - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              addr_gen_go,
    input  logic [LVL_W-1:0]  fft_level,
    output logic              addr_gen_busy,
    output logic              level_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic              fft_data_valid
);

    localparam int HALF = FFT_SIZE / 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [TW_W-1:0]  J_LAST       = TW_W'(HALF - 1);
    localparam logic [LVL_W-1:0] TW_SHIFT_MAX = LVL_W'(LEVELS - 1);

    // FSM and request state
    logic [0:0]        state_r;
    logic [LVL_W-1:0]  level_r;
    logic [TW_W-1:0]   j_r;
    logic              busy_r;
    logic              err_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_a_r;
    logic [ADDR_W-1:0] rd_b_r;
    logic [TW_W-1:0]   tw_r;

    // Write delay line
    logic              pipe_v_r [BFLY_LATENCY];
    logic [ADDR_W-1:0] pipe_a_r [BFLY_LATENCY];
    logic [ADDR_W-1:0] pipe_b_r [BFLY_LATENCY];

    // Address arithmetic for the request that will be registered next
    logic              level_ok_s;
    logic [LVL_W-1:0]  calc_level_s;
    logic [TW_W-1:0]   calc_j_s;
    logic [TW_W-1:0]   mask_s;
    logic [TW_W-1:0]   pos_s;
    logic [TW_W-1:0]   hi_s;
    logic [ADDR_W-1:0] span_s;
    logic [ADDR_W-1:0] addr_a_s;
    logic [ADDR_W-1:0] addr_b_s;
    logic [LVL_W-1:0]  tw_shift_s;
    logic [TW_W-1:0]   tw_s;

    // Compute the next request's addresses from (level, j).
    always_comb begin
        level_ok_s   = (int'(fft_level) < LEVELS);
        calc_level_s = fft_level;
        calc_j_s     = {TW_W{1'b0}};
        if (state_r == ST_ISSUE) begin
            // In ISSUE the registered outputs carry j_r; prepare j_r + 1.
            calc_level_s = level_r;
            calc_j_s     = j_r + {{(TW_W-1){1'b0}}, 1'b1};
        end else begin
            // In IDLE a go starts at j = 0 with the level on the port.
            calc_level_s = fft_level;
            calc_j_s     = {TW_W{1'b0}};
        end
        // mask = span-1; pos = j mod span; hi = (j div span) * span.
        mask_s   = ~({TW_W{1'b1}} << calc_level_s);
        pos_s    = calc_j_s & mask_s;
        hi_s     = calc_j_s & ~mask_s;
        span_s   = {{(ADDR_W-1){1'b0}}, 1'b1} << calc_level_s;
        // Shifting hi left once gives grp << (s+1); bit s is then always
        // clear, so B is A with that bit set and can never wrap.
        addr_a_s = {hi_s, 1'b0} | {1'b0, pos_s};
        addr_b_s = addr_a_s | span_s;
        // pos < 2^s, so shifting by LEVELS-1-s always fits in TW_W bits.
        tw_shift_s = TW_SHIFT_MAX - calc_level_s;
        tw_s       = pos_s << tw_shift_s;
    end

    // Request FSM: accept go in IDLE, then issue N/2 requests without stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            level_r <= {LVL_W{1'b0}};
            j_r     <= {TW_W{1'b0}};
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            rd_en_r <= 1'b0;
            rd_a_r  <= {ADDR_W{1'b0}};
            rd_b_r  <= {ADDR_W{1'b0}};
            tw_r    <= {TW_W{1'b0}};
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (addr_gen_go && level_ok_s) begin
                        state_r <= ST_ISSUE;
                        level_r <= fft_level;
                        j_r     <= {TW_W{1'b0}};
                        busy_r  <= 1'b1;
                        rd_en_r <= 1'b1;
                        rd_a_r  <= addr_a_s;
                        rd_b_r  <= addr_b_s;
                        tw_r    <= tw_s;
                    end else if (addr_gen_go) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // go is ignored here; the latched level stays put.
                    if (j_r == J_LAST) begin
                        state_r <= ST_IDLE;
                        j_r     <= {TW_W{1'b0}};
                        busy_r  <= 1'b0;
                        rd_en_r <= 1'b0;
                    end else begin
                        j_r    <= calc_j_s;
                        rd_a_r <= addr_a_s;
                        rd_b_r <= addr_b_s;
                        tw_r   <= tw_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Write delay line: always shifts, independent of the FSM, so writes of a
    // finished level drain unchanged while the next level is already reading.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                pipe_v_r[i] <= 1'b0;
                pipe_a_r[i] <= {ADDR_W{1'b0}};
                pipe_b_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            pipe_v_r[0] <= rd_en_r;
            pipe_a_r[0] <= rd_a_r;
            pipe_b_r[0] <= rd_b_r;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_a_r[i] <= pipe_a_r[i-1];
                pipe_b_r[i] <= pipe_b_r[i-1];
            end
        end
    end

    assign addr_gen_busy  = busy_r;
    assign level_err      = err_r;
    assign rd_en          = rd_en_r;
    assign rd_addr_a      = rd_a_r;
    assign rd_addr_b      = rd_b_r;
    assign tw_addr        = tw_r;
    assign wr_en          = pipe_v_r[BFLY_LATENCY-1];
    assign wr_addr_a      = pipe_a_r[BFLY_LATENCY-1];
    assign wr_addr_b      = pipe_b_r[BFLY_LATENCY-1];
    assign fft_data_valid = pipe_v_r[BFLY_LATENCY-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Testbench for fft_addr_gen: a 16-point instance carries the directed and
// randomized level sequences, a default 4096-point instance covers the
// out-of-range level error and the long last level. Expected reads, writes
// and error pulses are pushed into queues tagged with the cycle in which they
// must appear; a monitor pops and compares independently of the stimulus.
module tb_fft_addr_gen;

    localparam int LAT = 6;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset;
    logic go_a, go_b;
    logic [1:0] lvl_a;
    logic [3:0] lvl_b;

    logic busy_a, err_a, rd_a, wr_a, dv_a;
    logic [3:0] ra_a, rb_a, wa_a, wb_a;
    logic [2:0] tw_a;

    logic busy_b, err_b, rd_b, wr_b, dv_b;
    logic [11:0] ra_b, rb_b, wa_b, wb_b;
    logic [10:0] tw_b;

    fft_addr_gen #(.FFT_SIZE(16), .BFLY_LATENCY(LAT)) dut16 (
        .clk(clk), .reset(reset), .addr_gen_go(go_a), .fft_level(lvl_a),
        .addr_gen_busy(busy_a), .level_err(err_a), .rd_en(rd_a),
        .rd_addr_a(ra_a), .rd_addr_b(rb_a), .tw_addr(tw_a),
        .wr_en(wr_a), .wr_addr_a(wa_a), .wr_addr_b(wb_a),
        .fft_data_valid(dv_a)
    );

    fft_addr_gen dut4k (
        .clk(clk), .reset(reset), .addr_gen_go(go_b), .fft_level(lvl_b),
        .addr_gen_busy(busy_b), .level_err(err_b), .rd_en(rd_b),
        .rd_addr_a(ra_b), .rd_addr_b(rb_b), .tw_addr(tw_b),
        .wr_en(wr_b), .wr_addr_a(wa_b), .wr_addr_b(wb_b),
        .fft_data_valid(dv_b)
    );

    rec_t rdq_a[$], wrq_a[$], rdq_b[$], wrq_b[$];
    int   errq_a[$], errq_b[$];
    int   last_rd_a = -10, last_rd_b = -10;
    int   checks = 0, failures = 0;
    int   rd_cnt_b = 0, wr_cnt_b = 0;
    int   last_ra_b = 0, last_rb_b = 0, last_tw_b = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a level with stage s pairs element pos of each group of
    // 2*span with its partner span further on; twiddle step is N/(2*span).
    task automatic model_level(input int id, input int k, input int s, input int n);
        int span;
        rec_t r;
        span = 1 << s;
        for (int j = 0; j < n / 2; j++) begin
            r.a   = (j / span) * 2 * span + (j % span);
            r.b   = r.a + span;
            r.tw  = (j % span) * ((n / 2) / span);
            r.cyc = k + 1 + j;
            if (id == 0) rdq_a.push_back(r); else rdq_b.push_back(r);
            r.cyc = k + 1 + j + LAT;
            if (id == 0) wrq_a.push_back(r); else wrq_b.push_back(r);
        end
        if (id == 0) last_rd_a = k + n / 2; else last_rd_b = k + n / 2;
    endtask

    // Pulse go for one cycle (called at a negedge) and record the expectation.
    task automatic issue(input int id, input int lvl);
        int k, n, eff;
        bit idle;
        k = cyc;
        if (id == 0) begin
            n = 16; eff = lvl % 4; go_a = 1'b1; lvl_a = 2'(eff); idle = (k > last_rd_a);
        end else begin
            n = 4096; eff = lvl % 16; go_b = 1'b1; lvl_b = 4'(eff); idle = (k > last_rd_b);
        end
        if (idle) begin
            if (eff < $clog2(n)) model_level(id, k, eff, n);
            else if (id == 0) errq_a.push_back(k + 1);
            else errq_b.push_back(k + 1);
        end
        @(negedge clk);
        go_a = 1'b0;
        go_b = 1'b0;
    endtask

    task automatic take(input int id, input int kind, output bit have, output rec_t r);
        have = 1'b0;
        r = '{cyc: 0, a: 0, b: 0, tw: 0};
        if (id == 0 && kind == 0) begin
            if (rdq_a.size() > 0 && rdq_a[0].cyc == cyc) begin r = rdq_a.pop_front(); have = 1'b1; end
        end else if (id == 0) begin
            if (wrq_a.size() > 0 && wrq_a[0].cyc == cyc) begin r = wrq_a.pop_front(); have = 1'b1; end
        end else if (kind == 0) begin
            if (rdq_b.size() > 0 && rdq_b[0].cyc == cyc) begin r = rdq_b.pop_front(); have = 1'b1; end
        end else begin
            if (wrq_b.size() > 0 && wrq_b[0].cyc == cyc) begin r = wrq_b.pop_front(); have = 1'b1; end
        end
    endtask

    task automatic take_err(input int id, output bit have);
        have = 1'b0;
        if (id == 0) begin
            if (errq_a.size() > 0 && errq_a[0] == cyc) begin void'(errq_a.pop_front()); have = 1'b1; end
        end else begin
            if (errq_b.size() > 0 && errq_b[0] == cyc) begin void'(errq_b.pop_front()); have = 1'b1; end
        end
    endtask

    task automatic mon(input int id, input int busy, input int err, input int rd,
                       input int ra, input int rb, input int tw, input int wr,
                       input int dv, input int wa, input int wb);
        bit have;
        rec_t r;
        string p;
        p = (id == 0) ? "n16" : "n4k";
        take(id, 0, have, r);
        check({p, ".rd_en"}, rd, int'(have));
        check({p, ".busy"}, busy, int'(have));
        if (have && rd != 0) begin
            check({p, ".rd_addr_a"}, ra, r.a);
            check({p, ".rd_addr_b"}, rb, r.b);
            check({p, ".tw_addr"}, tw, r.tw);
        end
        take(id, 1, have, r);
        check({p, ".wr_en"}, wr, int'(have));
        check({p, ".fft_data_valid"}, dv, int'(have));
        if (have && wr != 0) begin
            check({p, ".wr_addr_a"}, wa, r.a);
            check({p, ".wr_addr_b"}, wb, r.b);
        end
        take_err(id, have);
        check({p, ".level_err"}, err, int'(have));
    endtask

    // Monitor: sample 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (cyc >= 1) begin
            mon(0, int'(busy_a), int'(err_a), int'(rd_a), int'(ra_a), int'(rb_a),
                int'(tw_a), int'(wr_a), int'(dv_a), int'(wa_a), int'(wb_a));
            mon(1, int'(busy_b), int'(err_b), int'(rd_b), int'(ra_b), int'(rb_b),
                int'(tw_b), int'(wr_b), int'(dv_b), int'(wa_b), int'(wb_b));
            if (rd_b) begin
                rd_cnt_b++;
                last_ra_b = int'(ra_b);
                last_rb_b = int'(rb_b);
                last_tw_b = int'(tw_b);
            end
            if (wr_b) wr_cnt_b++;
        end
    end

    task automatic wait_idle_a();
        while (cyc <= last_rd_a + LAT + 2) @(negedge clk);
    endtask

    int k_rst;

    initial begin
        reset = 1'b1;
        go_a = 1'b0; go_b = 1'b0;
        lvl_a = 2'd0; lvl_b = 4'd0;
        repeat (3) @(negedge clk);
        check("reset.rd_en", int'(rd_a), 0);
        check("reset.busy", int'(busy_a), 0);
        check("reset.level_err", int'(err_a), 0);
        check("reset.rd_addr_a", int'(ra_a), 0);
        check("reset.rd_addr_b", int'(rb_a), 0);
        check("reset.tw_addr", int'(tw_a), 0);
        check("reset.wr_en", int'(wr_a), 0);
        check("reset.wr_addr_a", int'(wa_a), 0);
        check("reset.wr_addr_b", int'(wb_a), 0);
        check("reset.n4k_rd_en", int'(rd_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed levels 0, 1, 3 (with an ignored go mid-issue).
        issue(0, 0); wait_idle_a();
        issue(0, 1); wait_idle_a();
        issue(0, 3);
        repeat (3) @(negedge clk);
        issue(0, 0);
        wait_idle_a();

        // Out-of-range level on the 4096-point instance.
        issue(1, 13);
        repeat (4) @(negedge clk);
        issue(1, 15);
        repeat (4) @(negedge clk);

        // Reset while j=3 of level 2 is on the read port.
        k_rst = cyc;
        issue(0, 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rdq_a.delete(); wrq_a.delete(); errq_a.delete();
        last_rd_a = k_rst + 4;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // Back-to-back: go on the first idle cycle while writes still drain.
        issue(0, 0);
        while (cyc < last_rd_a + 1) @(negedge clk);
        issue(0, 1);
        wait_idle_a();

        // Randomized gos on the small instance.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            issue(0, int'($urandom_range(0, 3)));
        end
        wait_idle_a();

        // Last level of the full-size transform, overlapped with random traffic.
        issue(1, 11);
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            issue(0, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 4000; i++) begin
            if (rdq_a.size() + wrq_a.size() + rdq_b.size() + wrq_b.size()
                + errq_a.size() + errq_b.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("drain.n16_reads", rdq_a.size(), 0);
        check("drain.n16_writes", wrq_a.size(), 0);
        check("drain.n4k_reads", rdq_b.size(), 0);
        check("drain.n4k_writes", wrq_b.size(), 0);
        check("drain.errors", errq_a.size() + errq_b.size(), 0);
        check("n4k.rd_count", rd_cnt_b, 2048);
        check("n4k.wr_count", wr_cnt_b, 2048);
        check("n4k.last_a", last_ra_b, 2047);
        check("n4k.last_b", last_rb_b, 4095);
        check("n4k.last_tw", last_tw_b, 2047);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
